// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One result bit per clock: radix-2 shift-add multiply, restoring divide.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [WIDTH-1:0]     mag_a_r, mag_b_r, a_keep_r;
    logic [2*WIDTH-1:0]   acc_r, acc_step_s;
    logic                 is_div_r, div0_r, neg_q_r, neg_r_r;
    logic                 busy_r, done_r;
    logic [WIDTH-1:0]     hi_r, lo_r, res_hi_s, res_lo_s;
    logic [WIDTH:0]       mul_sum_s, div_trial_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic                 sign_a_s, sign_b_s;

    // Two's-complement magnitude for signed operands, raw value otherwise
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        magnitude = neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    assign sign_a_s = ~op[0] & a[WIDTH-1];
    assign sign_b_s = ~op[0] & b[WIDTH-1];

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = CALC;
                else       state_s = IDLE;
            end
            CALC: begin
                if (cnt_r == LAST_CNT) state_s = FIX;
                else                   state_s = CALC;
            end
            FIX:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // One iteration: acc holds {partial product, multiplier} or {remainder, quotient}
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                    + (acc_r[0] ? {1'b0, mag_a_r} : {(WIDTH+1){1'b0}});
        div_trial_s = acc_r[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b_r};
        acc_step_s  = acc_r;
        if (is_div_r) begin
            if (!div_trial_s[WIDTH]) acc_step_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            else                     acc_step_s = {acc_r[2*WIDTH-2:0], 1'b0};
        end else begin
            acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Sign correction and divide-by-zero result selection
    always_comb begin
        prod_s   = neg_q_r ? (~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_r;
        res_hi_s = prod_s[2*WIDTH-1:WIDTH];
        res_lo_s = prod_s[WIDTH-1:0];
        if (div0_r) begin
            res_hi_s = a_keep_r;
            res_lo_s = {WIDTH{1'b1}};
        end else if (is_div_r) begin
            res_hi_s = magnitude(acc_r[2*WIDTH-1:WIDTH], neg_r_r);
            res_lo_s = magnitude(acc_r[WIDTH-1:0], neg_q_r);
        end else begin
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Operand latch, iteration datapath, HI/LO writes and status flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r    <= {CNT_W{1'b0}};
            mag_a_r  <= {WIDTH{1'b0}};
            mag_b_r  <= {WIDTH{1'b0}};
            a_keep_r <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            is_div_r <= 1'b0;
            div0_r   <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            busy_r <= (state_s != IDLE);
            done_r <= (state_r == FIX);
            case (state_r)
                IDLE: begin
                    if (hi_we) hi_r <= wdata;
                    if (lo_we) lo_r <= wdata;
                    if (start) begin
                        mag_a_r  <= magnitude(a, sign_a_s);
                        mag_b_r  <= magnitude(b, sign_b_s);
                        a_keep_r <= a;
                        acc_r    <= {{WIDTH{1'b0}}, (op[1] ? magnitude(a, sign_a_s) : magnitude(b, sign_b_s))};
                        is_div_r <= op[1];
                        div0_r   <= op[1] & (b == {WIDTH{1'b0}});
                        neg_q_r  <= sign_a_s ^ sign_b_s;
                        neg_r_r  <= sign_a_s;
                        cnt_r    <= {CNT_W{1'b0}};
                    end
                end
                CALC: begin
                    acc_r <= acc_step_s;
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                FIX: begin
                    hi_r <= res_hi_s;
                    lo_r <= res_lo_s;
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;
endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: WIDTH=32 and WIDTH=8 instances share clock and reset.
module tb_mdu_iter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        start32 = 1'b0, hi_we32 = 1'b0, lo_we32 = 1'b0, busy32, done32;
    logic [1:0]  op32 = 2'd0;
    logic [31:0] a32 = 32'd0, b32 = 32'd0, wdata32 = 32'd0, hi32, lo32;

    logic        start8 = 1'b0, busy8, done8;
    logic [1:0]  op8 = 2'd0;
    logic [7:0]  a8 = 8'd0, b8 = 8'd0, hi8, lo8;

    mdu_iter #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .hi_we(hi_we32), .lo_we(lo_we32), .wdata(wdata32),
        .busy(busy32), .done(done32), .hi(hi32), .lo(lo32));

    mdu_iter #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .hi_we(1'b0), .lo_we(1'b0), .wdata(8'd0),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8));

    int checks = 0;
    int failures = 0;
    logic [63:0] q32[$];
    logic [63:0] q8[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: compare each completion against the oldest expected result
    always @(negedge clock) begin
        if (done32) begin
            check_eq("sb32_pending", 64'(q32.size() > 0), 64'd1);
            if (q32.size() > 0) check_eq("res32", {hi32, lo32}, q32.pop_front());
        end
        if (done8) begin
            check_eq("sb8_pending", 64'(q8.size() > 0), 64'd1);
            if (q8.size() > 0) check_eq("res8", {48'd0, hi8, lo8}, q8.pop_front());
        end
    end

    task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] exp, input logic disturb,
                         output int bc, output int dc);
        logic [31:0] hi_before;
        hi_before = hi32;
        @(negedge clock);
        start32 = 1'b1; op32 = o; a32 = x; b32 = y;
        q32.push_back(exp);
        @(negedge clock);
        start32 = 1'b0; op32 = 2'd0; a32 = 32'd0; b32 = 32'd0;
        bc = busy32 ? 1 : 0;
        dc = done32 ? 1 : 0;
        for (int i = 1; i < 40; i++) begin
            @(negedge clock);
            if (busy32) bc++;
            if (done32) dc++;
            if (disturb && i == 5) begin
                start32 = 1'b1; a32 = 32'd1; b32 = 32'd1; hi_we32 = 1'b1; wdata32 = 32'h55;
            end else if (disturb && i == 6) begin
                start32 = 1'b0; a32 = 32'd0; b32 = 32'd0; hi_we32 = 1'b0; wdata32 = 32'd0;
            end
            if (i == 10) check_eq("hi_held_calc", {32'd0, hi32}, {32'd0, hi_before});
        end
        check_eq("sb32_drain", 64'(q32.size()), 64'd0);
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] exp);
        int bc;
        @(negedge clock);
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        q8.push_back({48'd0, exp});
        @(negedge clock);
        start8 = 1'b0;
        bc = busy8 ? 1 : 0;
        for (int i = 1; i < 16; i++) begin
            @(negedge clock);
            if (busy8) bc++;
        end
        check_eq("busy8_len", 64'(bc), 64'd9);
        check_eq("sb8_drain", 64'(q8.size()), 64'd0);
    endtask

    initial begin
        int bc, dc;
        #2;
        check_eq("rst_hilo32", {hi32, lo32}, 64'd0);
        check_eq("rst_flags32", {62'd0, busy32, done32}, 64'd0);
        check_eq("rst_hilo8", {48'd0, hi8, lo8}, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        run32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, bc, dc);
        check_eq("busy32_len", 64'(bc), 64'd33);
        check_eq("done32_cnt", 64'(dc), 64'd1);
        run32(2'b00, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1'b0, bc, dc);
        run32(2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, bc, dc);
        run32(2'b00, 32'd7, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFF2, 1'b0, bc, dc);
        run32(2'b10, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, bc, dc);
        run32(2'b11, 32'd10, 32'd0, 64'h0000000A_FFFFFFFF, 1'b0, bc, dc);
        run32(2'b10, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, 1'b0, bc, dc);
        run32(2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, bc, dc);
        run32(2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b1, bc, dc);
        check_eq("disturb_done_cnt", 64'(dc), 64'd1);
        check_eq("disturb_busy_len", 64'(bc), 64'd33);

        // Asynchronous reset in the middle of a MULTU
        @(negedge clock);
        start32 = 1'b1; op32 = 2'b01; a32 = 32'd9; b32 = 32'd9;
        @(negedge clock);
        start32 = 1'b0;
        repeat (9) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check_eq("async_rst_hilo", {hi32, lo32}, 64'd0);
        check_eq("async_rst_busy", {63'd0, busy32}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);
        check_eq("abort_no_result", {hi32, lo32}, 64'd0);

        @(negedge clock);
        lo_we32 = 1'b1; wdata32 = 32'h1234;
        @(negedge clock);
        lo_we32 = 1'b0;
        check_eq("mtlo", {32'd0, lo32}, 64'h1234);

        @(negedge clock);
        start32 = 1'b1; op32 = 2'b01; a32 = 32'd3; b32 = 32'd4; hi_we32 = 1'b1; wdata32 = 32'hAA;
        q32.push_back(64'h00000000_0000000C);
        @(negedge clock);
        start32 = 1'b0; hi_we32 = 1'b0;
        check_eq("mthi_with_start", {32'd0, hi32}, 64'hAA);
        check_eq("busy_after_e0", {63'd0, busy32}, 64'd1);
        for (int i = 0; i < 40; i++) @(negedge clock);
        check_eq("sb32_drain_final", 64'(q32.size()), 64'd0);

        run8(2'b00, 8'h80, 8'h80, 16'h4000);
        run8(2'b11, 8'hFF, 8'h10, 16'h0F0F);
        run8(2'b10, 8'hF9, 8'h02, 16'hFFFD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers, sitting beside the combinational ALU in the CPU datapath.
- Executes MULT, MULTU, DIV and DIVU as a radix-2 shift-add or restoring-divide loop, one result bit per clock.
- Provides MTHI/MTLO writes and continuous HI/LO read-out for MFHI/MFLO.
- The controller stalls the PC while busy=1.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; minimum value 4.

Ports:
clock  in  1  single clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  request operation; sampled only in IDLE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  in  WIDTH  rs operand (multiplicand / dividend)
b  in  WIDTH  rt operand (multiplier / divisor)
hi_we  in  1  MTHI write enable
lo_we  in  1  MTLO write enable
wdata  in  WIDTH  MTHI/MTLO write data
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0, internal operand registers=0.
  - Reset mid-operation aborts the operation; no partial result reaches hi/lo.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - Latch magnitudes of a and b. Signed ops take the two's-complement absolute value; unsigned ops take the raw value.
  - Record the result signs.
  - Counter=0, busy=1, state=CALC.
- CALC: one iteration per edge, counter increments each edge.
  - The edge where counter==WIDTH-1 performs the last iteration and moves to FIX.
  - CALC spans edges E1..E(WIDTH).
- FIX, edge E(WIDTH+1):
  - Apply sign correction.
  - Write hi and lo together.
  - busy=0, done=1, state=IDLE.
- done is high for exactly the one cycle after E(WIDTH+1).
- Latency: hi/lo hold the new values after edge E(WIDTH+1), i.e. WIDTH+1 edges after the start edge. A new start may be accepted at edge E(WIDTH+1)+1 or later.
- Multiply result:
  - Full 2*WIDTH-bit product; hi = upper half, lo = lower half.
  - MULT negates the 2W-bit product when the operand signs differ.
- Divide result:
  - lo = quotient, hi = remainder.
  - DIV quotient is negative iff the operand signs differ; remainder takes the sign of the dividend.
  - Truncation is toward zero.
- Divide by zero (b==0, DIV or DIVU): lo = all ones, hi = a unchanged, same latency.
- Signed overflow (DIV of -2^(WIDTH-1) by -1): lo = -2^(WIDTH-1), hi = 0. No exception.
- start while busy=1: ignored; no queuing, operands not re-latched.
- hi_we/lo_we in IDLE: hi/lo takes wdata at that edge.
  - hi_we and lo_we together update both.
  - Both are ignored while busy=1.
- start and hi_we/lo_we asserted in the same IDLE cycle:
  - Both take effect.
  - The write is visible after E0.
  - The write is overwritten by the result at E(WIDTH+1).
- hi/lo outputs are held constant during CALC; the intermediate accumulator is internal only.
- op values are latched at E0; later changes to op/a/b have no effect on the running operation.

Test Plan:
- WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 edges: hi=0xFFFFFFFE, lo=0x00000001, done pulse of 1 cycle, busy high for 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=10 b=0 -> lo=0xFFFFFFFF, hi=0x0000000A. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Busy-period interference:
  - Start DIVU 100/7, then pulse start with a=1,b=1 and hi_we with wdata=0x55 during CALC.
  - Required result: lo=14, hi=2; second start and write ignored; exactly one done pulse.
- Reset and write behaviour:
  - Drive reset=0 at cycle 10 of a MULTU: hi=lo=0, busy=0 immediately and asynchronously.
  - After release, lo_we with wdata=0x1234 gives lo=0x1234.
  - Then start MULTU 3*4 in the same cycle as hi_we with wdata=0xAA: hi=0xAA after E0, then hi=0, lo=12 after E33.
- WIDTH=8 instance:
  - MULT 0x80*0x80 -> hi=0x40, lo=0x00 after 9 edges.
  - DIVU 0xFF/0x10 -> lo=0x0F, hi=0x0F.
